// File: rtl/if_pkg.sv
// ============================================================================
// Module      : if_pkg
// Description : Shared IF-stage types and width constants for the IF2 slice.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package if_pkg;

    localparam int PC_W = 32;
    localparam int IR_W = 32;
    localparam int BT_W = 34;

    typedef struct packed {
        logic [PC_W-1:0] pc1;
        logic [PC_W-1:0] pc2;
        logic [IR_W-1:0] ir1;
        logic [IR_W-1:0] ir2;
        logic [BT_W-1:0] bt1;
        logic [BT_W-1:0] bt2;
        logic [1:0]      is_valid;
    } if_packet_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } redir_state_e;

endpackage

`default_nettype wire

// File: rtl/if2_fetch_redirect_ctrl.sv
// ============================================================================
// Module      : if2_fetch_redirect_ctrl
// Description : IF2 packet register, IQ handshake, predecoder redirect and
//               backend-flush arbitration.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module if2_fetch_redirect_ctrl #(
    parameter int PC_W = 32,
    parameter int IR_W = 32,
    parameter int BT_W = 34
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if1_valid,
    output logic            if2_ready,
    input  logic [PC_W-1:0] if1_pc1,
    input  logic [PC_W-1:0] if1_pc2,
    input  logic [IR_W-1:0] if1_ir1,
    input  logic [IR_W-1:0] if1_ir2,
    input  logic [BT_W-1:0] if1_bt1,
    input  logic [BT_W-1:0] if1_bt2,
    input  logic [1:0]      if1_is_valid,
    output logic [PC_W-1:0] pd_pc1,
    output logic [PC_W-1:0] pd_pc2,
    output logic [IR_W-1:0] pd_ir1,
    output logic [IR_W-1:0] pd_ir2,
    output logic [BT_W-1:0] pd_bt1,
    output logic [BT_W-1:0] pd_bt2,
    output logic [1:0]      pd_is_valid,
    input  logic [1:0]      pd_o_is_valid,
    input  logic            pd_br,
    input  logic [PC_W-1:0] pd_pc_fact,
    input  logic [BT_W-1:0] pd_type1,
    input  logic [BT_W-1:0] pd_type2,
    output logic            iq_valid,
    input  logic            iq_ready,
    output logic [PC_W-1:0] iq_pc1,
    output logic [PC_W-1:0] iq_pc2,
    output logic [IR_W-1:0] iq_ir1,
    output logic [IR_W-1:0] iq_ir2,
    output logic [BT_W-1:0] iq_type1,
    output logic [BT_W-1:0] iq_type2,
    output logic [1:0]      iq_is_valid,
    input  logic            be_flush,
    output logic            if1_flush,
    output logic            redir_valid,
    output logic [PC_W-1:0] redir_pc,
    input  logic            redir_ready,
    output logic [31:0]     pd_redir_cnt
);

    import if_pkg::*;

    redir_state_e    r_state;
    redir_state_e    w_state_nxt;
    logic            r_v;
    logic [PC_W-1:0] r_pc1;
    logic [PC_W-1:0] r_pc2;
    logic [IR_W-1:0] r_ir1;
    logic [IR_W-1:0] r_ir2;
    logic [BT_W-1:0] r_bt1;
    logic [BT_W-1:0] r_bt2;
    logic [1:0]      r_is_valid;
    logic [PC_W-1:0] r_redir_pc;
    logic [31:0]     r_redir_cnt;

    logic w_idle;
    logic w_hs;
    logic w_hs_br;
    logic w_load;

    assign w_idle    = (r_state == IDLE);
    assign iq_valid  = r_v & w_idle & ~be_flush;
    assign w_hs      = iq_valid & iq_ready;
    // A redirecting packet must not admit its wrong-path successor.
    assign w_hs_br   = w_hs & pd_br;
    assign if2_ready = w_idle & (~r_v | w_hs) & ~w_hs_br;
    assign w_load    = if1_valid & if2_ready & ~be_flush;
    assign if1_flush = be_flush | w_hs_br;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs_br)     w_state_nxt = REDIR;
            REDIR:   if (redir_ready) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
        if (be_flush) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v        <= 1'b0;
            r_pc1      <= '0;
            r_pc2      <= '0;
            r_ir1      <= '0;
            r_ir2      <= '0;
            r_bt1      <= '0;
            r_bt2      <= '0;
            r_is_valid <= '0;
        end else begin
            if (be_flush) begin
                r_v <= 1'b0;
            end else if (w_load) begin
                r_v <= 1'b1;
            end else if (w_hs) begin
                r_v <= 1'b0;
            end
            if (w_load) begin
                r_pc1      <= if1_pc1;
                r_pc2      <= if1_pc2;
                r_ir1      <= if1_ir1;
                r_ir2      <= if1_ir2;
                r_bt1      <= if1_bt1;
                r_bt2      <= if1_bt2;
                r_is_valid <= if1_is_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_redir_pc  <= '0;
            r_redir_cnt <= '0;
        end else if (w_hs_br) begin
            r_redir_pc  <= pd_pc_fact;
            r_redir_cnt <= r_redir_cnt + 32'd1;
        end
    end

    assign pd_pc1       = r_pc1;
    assign pd_pc2       = r_pc2;
    assign pd_ir1       = r_ir1;
    assign pd_ir2       = r_ir2;
    assign pd_bt1       = r_bt1;
    assign pd_bt2       = r_bt2;
    assign pd_is_valid  = r_is_valid;

    assign iq_pc1       = r_pc1;
    assign iq_pc2       = r_pc2;
    assign iq_ir1       = r_ir1;
    assign iq_ir2       = r_ir2;
    assign iq_type1     = pd_type1;
    assign iq_type2     = pd_type2;
    assign iq_is_valid  = r_is_valid & pd_o_is_valid;

    assign redir_valid  = (r_state == REDIR);
    assign redir_pc     = r_redir_pc;
    assign pd_redir_cnt = r_redir_cnt;

endmodule

`default_nettype wire
